// File: rtl/mux_select_arbiter_pkg.sv
// Shared encodings for the two-channel mux select arbiter.
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic logic [1:0] grant_state(input logic ch);
    return (ch == CH1) ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the two requesters, the arbiter and the mux select.
interface mux_select_arbiter_if;
  logic Req0;
  logic Req1;
  logic Gnt0;
  logic Gnt1;
  logic Sel;
  logic Busy;
  logic Preempt;

  modport master (output Req0, Req1, input Gnt0, Gnt1, Sel, Busy, Preempt);
  modport slave  (input Req0, Req1, output Gnt0, Gnt1, Sel, Busy, Preempt);
endinterface

// File: rtl/mux_select_arbiter_hold_counter.sv
// Grant tenure counter; wraps at MAX_HOLD-1 and flags the last allowed cycle.
module hold_counter #(
  parameter int  MAX_HOLD = 8,
  localparam int CW       = $clog2(MAX_HOLD)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clr,
  input  logic          En,
  output logic [CW-1:0] Cnt,
  output logic          AtMax
);

  assign AtMax = (Cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      Cnt <= '0;
    else if (Clr)
      Cnt <= '0;
    else if (En)
      Cnt <= AtMax ? '0 : Cnt + CW'(1);
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the select of a 2:1 data mux, with a hold
// limit that only bites while the other channel is waiting.
//
//   state   | meaning
//   IDLE    | nobody owns the mux; Sel keeps its last value
//   G0      | channel 0 owns the mux (Sel=0)
//   G1      | channel 1 owns the mux (Sel=1)
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  mux_select_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_HOLD);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          last_gnt;
  logic          sel_q;
  logic          preempt_q;
  logic          preempt_next;
  logic          entering;
  logic          hold_clr;
  logic          hold_en;
  logic          at_max;
  // Tenure count is only consumed through AtMax.
  logic [CW-1:0] hold_cnt_unused;

  hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clr   (hold_clr),
    .En    (hold_en),
    .Cnt   (hold_cnt_unused),
    .AtMax (at_max)
  );

  always_comb begin
    state_next   = state;
    preempt_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Req0 && bus.Req1)
          state_next = grant_state(~last_gnt);
        else if (bus.Req0)
          state_next = ST_G0;
        else if (bus.Req1)
          state_next = ST_G1;
      end
      ST_G0: begin
        if (!bus.Req0) begin
          state_next = bus.Req1 ? ST_G1 : ST_IDLE;
        end else if (bus.Req1 && at_max) begin
          state_next   = ST_G1;
          preempt_next = 1'b1;
        end
      end
      ST_G1: begin
        if (!bus.Req1) begin
          state_next = bus.Req0 ? ST_G0 : ST_IDLE;
        end else if (bus.Req0 && at_max) begin
          state_next   = ST_G0;
          preempt_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign entering = (state_next != state) && (state_next != ST_IDLE);
  assign hold_clr = entering || (state == ST_IDLE);
  assign hold_en  = (state != ST_IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      last_gnt  <= CH1;
      sel_q     <= CH0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_next;
      preempt_q <= preempt_next;
      if (entering) begin
        last_gnt <= (state_next == ST_G1) ? CH1 : CH0;
        sel_q    <= (state_next == ST_G1) ? CH1 : CH0;
      end
    end
  end

  assign bus.Gnt0    = (state == ST_G0);
  assign bus.Gnt1    = (state == ST_G1);
  assign bus.Busy    = (state == ST_G0) || (state == ST_G1);
  assign bus.Sel     = sel_q;
  assign bus.Preempt = preempt_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench: a tenure-based reference model queues expected outputs
// per clock; a monitor pops and compares on the falling edge.
module tb_mux_select_arbiter;

  localparam int MAX_HOLD = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  mux_select_arbiter_if bus();

  mux_select_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic g0;
    logic g1;
    logic sel;
    logic busy;
    logic pre;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   pre_seen = 0;
  bit   started  = 1'b0;

  // Reference model: who owns the mux, how long they have had it, who won last.
  int owner = -1;
  int last  = 1;
  int held  = 0;
  bit m_sel = 1'b0;
  bit m_pre = 1'b0;

  task automatic give(input int ch, input bit pre);
    owner = ch;
    last  = ch;
    held  = 1;
    m_sel = (ch == 1);
    m_pre = pre;
  endtask

  initial begin : model
    bit   r[2];
    int   o;
    exp_t e;
    forever begin
      @(posedge Clk);
      r[0]  = bus.Req0;
      r[1]  = bus.Req1;
      m_pre = 1'b0;
      if (Rst) begin
        owner = -1;
        last  = 1;
        held  = 0;
        m_sel = 1'b0;
      end else if (owner < 0) begin
        if (r[0] && r[1])
          give(1 - last, 1'b0);
        else if (r[0])
          give(0, 1'b0);
        else if (r[1])
          give(1, 1'b0);
      end else begin
        o = owner;
        if (!r[o]) begin
          if (r[1-o]) give(1 - o, 1'b0);
          else        owner = -1;
        end else if (r[1-o] && held == MAX_HOLD) begin
          give(1 - o, 1'b1);
        end else begin
          held = (held == MAX_HOLD) ? 1 : held + 1;
        end
      end
      e.g0   = (owner == 0);
      e.g1   = (owner == 1);
      e.sel  = m_sel;
      e.busy = (owner >= 0);
      e.pre  = m_pre;
      exp_q.push_back(e);
      started = 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge Clk);
      if (started) begin
        got = {bus.Gnt0, bus.Gnt1, bus.Sel, bus.Busy, bus.Preempt};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at %0t: got %b, no expectation queued", $time, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL outputs at %0t: got g0g1/sel/busy/pre=%b required %b", $time, got, e);
          end
        end
        checks++;
        if (bus.Gnt0 === 1'b1 && bus.Gnt1 === 1'b1) begin
          errors++;
          $display("FAIL onehot at %0t: got Gnt0=1 Gnt1=1 required at most one", $time);
        end
        if (bus.Preempt === 1'b1) pre_seen++;
      end
    end
  end

  task automatic drive(input bit a, input bit b, input int n);
    repeat (n) begin
      @(negedge Clk);
      bus.Req0 = a;
      bus.Req1 = b;
    end
  endtask

  task automatic check_count(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin : stim
    int p0;
    bit a;
    bit b;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    #2 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b0;

    drive(0, 0, 3);
    p0 = pre_seen;
    drive(1, 0, 20);
    drive(0, 0, 3);
    check_count("single_no_preempt", pre_seen - p0, 0);

    p0 = pre_seen;
    drive(1, 1, 40);
    check_count("contention_preempts", pre_seen - p0, 4);

    drive(0, 0, 2);
    drive(1, 0, 3);
    p0 = pre_seen;
    drive(0, 1, 4);
    drive(0, 0, 4);
    check_count("handoff_no_preempt", pre_seen - p0, 0);

    drive(1, 0, 3);
    drive(0, 0, 2);
    drive(1, 1, 5);
    drive(0, 0, 2);

    drive(0, 1, 4);
    #1 Rst = 1'b1;
    #1 check_count("async_reset_outputs",
                   {bus.Gnt0, bus.Gnt1, bus.Sel, bus.Busy, bus.Preempt}, 0);
    repeat (2) @(negedge Clk);
    bus.Req0 = 1'b1;
    bus.Req1 = 1'b1;
    #1 Rst = 1'b0;
    drive(1, 1, 6);

    a = 1'b0;
    b = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 5) == 0) b = ~b;
      drive(a, b, 1);
    end

    drive(0, 0, 3);
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
